// File: rtl/valid_ready_round_robin_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : valid_ready_round_robin_arbiter_if
// Description : Handshake bundle for the round-robin arbiter. It carries the
//               per-channel write side and the single registered read side.
// Revision    : 1.0 - initial release
// ============================================================================
interface valid_ready_round_robin_arbiter_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int CHANNEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] write_data;
  logic [CHANNELS-1:0]       write_valid;
  logic [CHANNELS-1:0]       write_last;
  logic [CHANNELS-1:0]       write_ready;
  logic [WIDTH-1:0]          read_data;
  logic [CHANNEL_WIDTH-1:0]  read_channel;
  logic                      read_last;
  logic                      read_valid;
  logic                      read_ready;

  // Requester/consumer side: drives the write bundle and the downstream ready
  modport master (
    output write_data, write_valid, write_last, read_ready,
    input  write_ready, read_data, read_channel, read_last, read_valid
  );

  // Arbiter side
  modport slave (
    input  write_data, write_valid, write_last, read_ready,
    output write_ready, read_data, read_channel, read_last, read_valid
  );
endinterface
`default_nettype wire

// File: rtl/valid_ready_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : valid_ready_round_robin_arbiter
// Description : Round-robin arbiter sharing one valid-ready sink between
//               CHANNELS requesters. Multi-beat packets lock the grant until
//               their last beat. Output is a one-entry registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module valid_ready_round_robin_arbiter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic clock,
  input  logic reset,
  valid_ready_round_robin_arbiter_if.slave bus
);
  localparam int CHANNEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CHANNEL_WIDTH-1:0] LAST_CHANNEL = CHANNEL_WIDTH'(CHANNELS - 1);
  localparam logic [CHANNEL_WIDTH-1:0] ONE_CHANNEL  = CHANNEL_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] pointer_q, pointer_d;
  logic [CHANNEL_WIDTH-1:0] locked_q, locked_d;
  logic [WIDTH-1:0]         read_data_q, read_data_d;
  logic [CHANNEL_WIDTH-1:0] read_channel_q, read_channel_d;
  logic                     read_last_q, read_last_d;
  logic                     read_valid_q, read_valid_d;

  logic                     accept;
  logic [CHANNEL_WIDTH-1:0] rr_grant;
  logic                     rr_found;
  logic [CHANNEL_WIDTH-1:0] rr_idx;
  logic [CHANNEL_WIDTH-1:0] grant;
  logic                     grant_valid;
  logic [CHANNEL_WIDTH-1:0] grant_next;
  logic                     beat;
  logic [WIDTH-1:0]         beat_data;
  logic                     beat_last;
  logic [CHANNELS-1:0]      ready_vec;

  // Round-robin search: first valid channel starting at the pointer, wrapping at CHANNELS-1
  always_comb begin
    rr_grant = pointer_q;
    rr_found = 1'b0;
    rr_idx   = pointer_q;
    for (int off = 0; off < CHANNELS; off++) begin
      if (!rr_found && bus.write_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
      rr_idx = (rr_idx == LAST_CHANNEL) ? '0 : rr_idx + ONE_CHANNEL;
    end
  end

  // Grant selection, beat mux and per-channel ready; reset suppresses any transfer
  always_comb begin
    accept = ~read_valid_q | bus.read_ready;
    if (state_q == LOCKED) begin
      grant       = locked_q;
      grant_valid = bus.write_valid[locked_q];
    end else begin
      grant       = rr_grant;
      grant_valid = rr_found;
    end
    beat       = accept & grant_valid & ~reset;
    grant_next = (grant == LAST_CHANNEL) ? '0 : grant + ONE_CHANNEL;
    beat_data  = '0;
    beat_last  = 1'b0;
    ready_vec  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == CHANNEL_WIDTH'(i)) begin
        beat_data    = bus.write_data[i*WIDTH +: WIDTH];
        beat_last    = bus.write_last[i];
        ready_vec[i] = beat;
      end
    end
  end

  // Next state: load the output stage on a beat, drain it otherwise; pointer moves only on packet end
  always_comb begin
    state_d        = state_q;
    pointer_d      = pointer_q;
    locked_d       = locked_q;
    read_data_d    = read_data_q;
    read_channel_d = read_channel_q;
    read_last_d    = read_last_q;
    read_valid_d   = read_valid_q;
    if (beat) begin
      read_data_d    = beat_data;
      read_channel_d = grant;
      read_last_d    = beat_last;
      read_valid_d   = 1'b1;
      if (beat_last) begin
        state_d   = IDLE;
        pointer_d = grant_next;
      end else begin
        state_d  = LOCKED;
        locked_d = grant;
      end
    end else if (bus.read_ready) begin
      read_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any lock and buffered beat
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      pointer_q      <= '0;
      locked_q       <= '0;
      read_data_q    <= '0;
      read_channel_q <= '0;
      read_last_q    <= 1'b0;
      read_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pointer_q      <= pointer_d;
      locked_q       <= locked_d;
      read_data_q    <= read_data_d;
      read_channel_q <= read_channel_d;
      read_last_q    <= read_last_d;
      read_valid_q   <= read_valid_d;
    end
  end

  assign bus.write_ready  = ready_vec;
  assign bus.read_data    = read_data_q;
  assign bus.read_channel = read_channel_q;
  assign bus.read_last    = read_last_q;
  assign bus.read_valid   = read_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_valid_ready_round_robin_arbiter
// Description : Directed bench for the round-robin arbiter: a 4-channel and a
//               3-channel instance driven with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_valid_ready_round_robin_arbiter;
  localparam int WIDTH = 8;
  localparam int CH_A  = 4;
  localparam int CH_B  = 3;

  logic clock = 1'b0;
  logic reset;
  int   total;
  int   bad;

  always #5 clock = ~clock;

  valid_ready_round_robin_arbiter_if #(.WIDTH(WIDTH), .CHANNELS(CH_A)) bus_a ();
  valid_ready_round_robin_arbiter_if #(.WIDTH(WIDTH), .CHANNELS(CH_B)) bus_b ();

  valid_ready_round_robin_arbiter #(.WIDTH(WIDTH), .CHANNELS(CH_A)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  valid_ready_round_robin_arbiter #(.WIDTH(WIDTH), .CHANNELS(CH_B)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Checks the registered output beat of instance A
  task automatic check_a(input string tag, input logic [1:0] ch, input logic [7:0] data, input logic last);
    check_value({tag, "_valid"}, 32'(bus_a.read_valid), 32'd1);
    check_value({tag, "_chan"},  32'(bus_a.read_channel), 32'(ch));
    check_value({tag, "_data"},  32'(bus_a.read_data), 32'(data));
    check_value({tag, "_last"},  32'(bus_a.read_last), 32'(last));
  endtask

  task automatic check_b(input string tag, input logic [1:0] ch, input logic [7:0] data);
    check_value({tag, "_valid"}, 32'(bus_b.read_valid), 32'd1);
    check_value({tag, "_chan"},  32'(bus_b.read_channel), 32'(ch));
    check_value({tag, "_data"},  32'(bus_b.read_data), 32'(data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] fair_seq [6];
    logic [3:0] fair_rdy [6];
    fair_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    fair_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    total = 0;
    bad   = 0;

    // Reset with every channel requesting
    reset             = 1'b1;
    bus_a.write_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus_a.write_valid = 4'b1111;
    bus_a.write_last  = 4'b1111;
    bus_a.read_ready  = 1'b1;
    bus_b.write_data  = {8'hB2, 8'hB1, 8'hB0};
    bus_b.write_valid = 3'b000;
    bus_b.write_last  = 3'b111;
    bus_b.read_ready  = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check_value("rst_rvalid", 32'(bus_a.read_valid), 32'd0);
      check_value("rst_wready", 32'(bus_a.write_ready), 32'd0);
      check_value("rst_rchan",  32'(bus_a.read_channel), 32'd0);
    end
    reset = 1'b0;
    #1;
    check_value("rel_rvalid", 32'(bus_a.read_valid), 32'd0);
    check_value("rel_wready", 32'(bus_a.write_ready), 32'b0001);

    // Fairness: single-beat packets, one beat per cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_a("fair", fair_seq[k], 8'hA0 + 8'(fair_seq[k]), 1'b1);
      check_value("fair_wready", 32'(bus_a.write_ready), 32'(fair_rdy[k]));
    end

    // Move pointer to 1 with a lone ch0 packet
    bus_a.write_valid = 4'b0001;
    #1;
    check_value("solo0_wready", 32'(bus_a.write_ready), 32'b0001);
    @(negedge clock);
    check_a("solo0", 2'd0, 8'hA0, 1'b1);

    // Lock: ch1 three-beat packet with ch0/ch2 also requesting
    bus_a.write_valid      = 4'b0111;
    bus_a.write_last       = 4'b1101;
    bus_a.write_data[15:8] = 8'h11;
    #1;
    check_value("lock1_wready", 32'(bus_a.write_ready), 32'b0010);
    @(negedge clock);
    check_a("lock1", 2'd1, 8'h11, 1'b0);
    bus_a.write_data[15:8] = 8'h12;
    #1;
    check_value("lock2_wready", 32'(bus_a.write_ready), 32'b0010);
    @(negedge clock);
    check_a("lock2", 2'd1, 8'h12, 1'b0);
    bus_a.write_data[15:8] = 8'h13;
    bus_a.write_last       = 4'b1111;
    #1;
    check_value("lock3_wready", 32'(bus_a.write_ready), 32'b0010);
    @(negedge clock);
    check_a("lock3", 2'd1, 8'h13, 1'b1);
    #1;
    check_value("unlock_wready", 32'(bus_a.write_ready), 32'b0100);
    @(negedge clock);
    check_a("unlock", 2'd2, 8'hA2, 1'b1);

    // Back-pressure: output held with ch2 beat, pointer at 3
    bus_a.read_ready       = 1'b0;
    bus_a.write_valid      = 4'b1111;
    bus_a.write_data[15:8] = 8'hA1;
    #1;
    check_value("bp_wready0", 32'(bus_a.write_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_a("bp_hold", 2'd2, 8'hA2, 1'b1);
      check_value("bp_wready", 32'(bus_a.write_ready), 32'd0);
    end
    bus_a.read_ready = 1'b1;
    #1;
    check_value("bp_release_wready", 32'(bus_a.write_ready), 32'b1000);
    @(negedge clock);
    check_a("bp_release", 2'd3, 8'hA3, 1'b1);

    // Reset mid-packet: ch3 locked with its first beat buffered
    bus_a.write_valid = 4'b1000;
    bus_a.write_last  = 4'b0111;
    #1;
    check_value("mid_wready", 32'(bus_a.write_ready), 32'b1000);
    @(negedge clock);
    check_a("mid_beat", 2'd3, 8'hA3, 1'b0);
    bus_a.read_ready  = 1'b0;
    bus_a.write_valid = 4'b1111;
    #1;
    check_value("mid_stall_wready", 32'(bus_a.write_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_value("mid_rst_rvalid", 32'(bus_a.read_valid), 32'd0);
    check_value("mid_rst_wready", 32'(bus_a.write_ready), 32'd0);
    reset            = 1'b0;
    bus_a.read_ready = 1'b1;
    #1;
    check_value("post_rst_wready", 32'(bus_a.write_ready), 32'b0001);
    @(negedge clock);
    check_a("post_rst", 2'd0, 8'hA0, 1'b1);
    bus_a.write_valid = 4'b0000;
    @(negedge clock);
    check_value("drain_rvalid", 32'(bus_a.read_valid), 32'd0);

    // Three-channel wrap/skip
    bus_b.write_valid = 3'b010;
    #1;
    check_value("b1_wready", 32'(bus_b.write_ready), 32'b010);
    @(negedge clock);
    check_b("b1", 2'd1, 8'hB1);
    bus_b.write_valid = 3'b001;
    #1;
    check_value("wrap0_wready", 32'(bus_b.write_ready), 32'b001);
    @(negedge clock);
    check_b("wrap0", 2'd0, 8'hB0);
    bus_b.write_valid = 3'b100;
    #1;
    check_value("skip2_wready", 32'(bus_b.write_ready), 32'b100);
    @(negedge clock);
    check_b("skip2", 2'd2, 8'hB2);
    bus_b.write_valid = 3'b111;
    #1;
    check_value("ptr0_wready", 32'(bus_b.write_ready), 32'b001);
    @(negedge clock);
    check_b("ptr0", 2'd0, 8'hB0);
    bus_b.write_valid = 3'b000;
    @(negedge clock);
    check_value("b_drain_rvalid", 32'(bus_b.read_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
